// File: rtl/vram_fill_master.sv
// vram_fill_master: Avalon-MM master that fills a window of video memory with a
// constant or incrementing pattern and can read the window back to check it.
//
// Handshake: a command (AVL_M_WRITE or AVL_M_READ) is offered with its address,
// byte enables and data. It stays stable until a cycle in which AVL_M_WAITREQUEST
// is 0. The transfer completes at the rising edge that ends that cycle. Read data
// is taken only in a cycle with AVL_M_READDATAVALID=1. At most one read is in
// flight at any time.
module vram_fill_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W-1:0] COUNT,
  input  logic [DATA_W-1:0] PATTERN,
  input  logic              INC,
  input  logic              VERIFY,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] ERR_ADDR,
  output logic [ADDR_W-1:0] AVL_M_ADDR,
  output logic              AVL_M_READ,
  output logic              AVL_M_WRITE,
  output logic [3:0]        AVL_M_BYTE_EN,
  output logic [DATA_W-1:0] AVL_M_WRITEDATA,
  input  logic [DATA_W-1:0] AVL_M_READDATA,
  input  logic              AVL_M_WAITREQUEST,
  input  logic              AVL_M_READDATAVALID,
  output logic [2:0]        DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;

  // Command parameters captured when a START is accepted.
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic              inc_q, inc_d;
  logic              verify_q, verify_d;

  // Walking state for the current pass (write or read-back).
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] rem_q, rem_d;

  // Read-back result, held until the next accepted START.
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  // Values of the walking state one word further on. Address and data wrap
  // naturally at their register widths.
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [ADDR_W-1:0] rem_nxt;
  logic              last_word;

  assign addr_nxt  = addr_q + ONE_A;
  assign data_nxt  = data_q + {{(DATA_W-1){1'b0}}, inc_q};
  assign rem_nxt   = rem_q - ONE_A;
  assign last_word = (rem_q == ONE_A);

  // State and datapath registers; reset abandons any operation in progress.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      pattern_q  <= '0;
      inc_q      <= 1'b0;
      verify_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      pattern_q  <= pattern_d;
      inc_q      <= inc_d;
      verify_q   <= verify_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Next-state and datapath update: each state advances only on a completed
  // bus transfer, so everything the bus sees is frozen during a stall.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    pattern_d  = pattern_q;
    inc_d      = inc_q;
    verify_d   = verify_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rem_d      = rem_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          base_d     = BASE_ADDR;
          count_d    = COUNT;
          pattern_d  = PATTERN;
          inc_d      = INC;
          verify_d   = VERIFY;
          addr_d     = BASE_ADDR;
          data_d     = PATTERN;
          rem_d      = COUNT;
          err_d      = 1'b0;
          err_addr_d = '0;
          state_d    = (COUNT == '0) ? S_FIN : S_WR;
        end
      end

      S_WR: begin
        if (!AVL_M_WAITREQUEST) begin
          addr_d = addr_nxt;
          data_d = data_nxt;
          rem_d  = rem_nxt;
          if (last_word) begin
            if (verify_q) begin
              // Rewind to the start of the window for the read-back pass.
              addr_d  = base_q;
              data_d  = pattern_q;
              rem_d   = count_q;
              state_d = S_RD_REQ;
            end else begin
              state_d = S_FIN;
            end
          end
        end
      end

      S_RD_REQ: begin
        if (!AVL_M_WAITREQUEST) begin
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (AVL_M_READDATAVALID) begin
          if (AVL_M_READDATA != data_q) begin
            // First mismatch ends the check; later words are not read.
            err_d      = 1'b1;
            err_addr_d = addr_q;
            state_d    = S_FIN;
          end else begin
            addr_d  = addr_nxt;
            data_d  = data_nxt;
            rem_d   = rem_nxt;
            state_d = last_word ? S_FIN : S_RD_REQ;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus command and status outputs decoded from the current state; address and
  // data buses are driven to zero whenever no command is offered.
  always_comb begin
    BUSY            = 1'b0;
    DONE            = 1'b0;
    AVL_M_ADDR      = '0;
    AVL_M_READ      = 1'b0;
    AVL_M_WRITE     = 1'b0;
    AVL_M_BYTE_EN   = 4'b0000;
    AVL_M_WRITEDATA = '0;

    unique case (state_q)
      S_IDLE: begin
      end
      S_WR: begin
        BUSY            = 1'b1;
        AVL_M_WRITE     = 1'b1;
        AVL_M_BYTE_EN   = 4'b1111;
        AVL_M_ADDR      = addr_q;
        AVL_M_WRITEDATA = data_q;
      end
      S_RD_REQ: begin
        BUSY          = 1'b1;
        AVL_M_READ    = 1'b1;
        AVL_M_BYTE_EN = 4'b1111;
        AVL_M_ADDR    = addr_q;
      end
      S_RD_WAIT: begin
        BUSY = 1'b1;
      end
      S_FIN: begin
        DONE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ERR       = err_q;
  assign ERR_ADDR  = err_addr_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_vram_fill_master.sv
// Bench for vram_fill_master: a table of fill commands runs against a slave
// model. The slave keeps a word memory, can insert random wait states and
// read latency, and can corrupt one word on read-back. Expected writes and reads
// are queued when a command is issued and are checked off as the bus completes
// them.
module tb_vram_fill_master;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          START = 1'b0;
  logic [AW-1:0] BASE_ADDR = '0;
  logic [AW-1:0] COUNT = '0;
  logic [DW-1:0] PATTERN = '0;
  logic          INC = 1'b0;
  logic          VERIFY = 1'b0;
  logic          BUSY, DONE, ERR;
  logic [AW-1:0] ERR_ADDR;
  logic [AW-1:0] AVL_M_ADDR;
  logic          AVL_M_READ, AVL_M_WRITE;
  logic [3:0]    AVL_M_BYTE_EN;
  logic [DW-1:0] AVL_M_WRITEDATA;
  logic [DW-1:0] AVL_M_READDATA = '0;
  logic          AVL_M_WAITREQUEST = 1'b0;
  logic          AVL_M_READDATAVALID = 1'b0;
  logic [2:0]    DBG_STATE;

  vram_fill_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .START               (START),
    .BASE_ADDR           (BASE_ADDR),
    .COUNT               (COUNT),
    .PATTERN             (PATTERN),
    .INC                 (INC),
    .VERIFY              (VERIFY),
    .BUSY                (BUSY),
    .DONE                (DONE),
    .ERR                 (ERR),
    .ERR_ADDR            (ERR_ADDR),
    .AVL_M_ADDR          (AVL_M_ADDR),
    .AVL_M_READ          (AVL_M_READ),
    .AVL_M_WRITE         (AVL_M_WRITE),
    .AVL_M_BYTE_EN       (AVL_M_BYTE_EN),
    .AVL_M_WRITEDATA     (AVL_M_WRITEDATA),
    .AVL_M_READDATA      (AVL_M_READDATA),
    .AVL_M_WAITREQUEST   (AVL_M_WAITREQUEST),
    .AVL_M_READDATAVALID (AVL_M_READDATAVALID),
    .DBG_STATE           (DBG_STATE)
  );

  // ---------------- clock ----------------
  always #10 CLK = ~CLK;

  // ---------------- shared state ----------------
  int unsigned   checks = 0;
  int unsigned   errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW+DW-1:0] exp_q[$];      // {addr, data} of each expected write
  logic [AW-1:0]    exp_rd_q[$];   // addr of each expected read

  // Written only by the main process.
  logic          stall_mode = 1'b0;
  int unsigned   rd_extra = 0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  int unsigned   rd_due = 0;
  int unsigned   rd_issue = 0;
  logic          prev_stall = 1'b0;
  logic [AW+DW+6:0] prev_cmd = '0;

  // Written only by the slave driver.
  int unsigned   cyc_ctr = 0;
  int unsigned   rd_served = 0;

  // ---------------- slave driver ----------------
  // Drives wait states and read responses just after each rising edge.
  always @(posedge CLK) begin
    #1;
    cyc_ctr = cyc_ctr + 1;
    AVL_M_WAITREQUEST = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    AVL_M_READDATAVALID = 1'b0;
    AVL_M_READDATA = $urandom;
    if (rd_issue != rd_served && cyc_ctr >= rd_due) begin
      AVL_M_READDATAVALID = 1'b1;
      AVL_M_READDATA = mem[rd_addr] ^
        ((corrupt_en && rd_addr == corrupt_addr) ? 32'h0000_0001 : 32'h0);
      rd_served = rd_served + 1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observes one bus cycle at the falling edge and scores it.
  task automatic monitor();
    logic [AW+DW-1:0] e;
    logic [AW+DW+6:0] cur;
    cur = {AVL_M_READ, AVL_M_WRITE, AVL_M_BYTE_EN, AVL_M_WRITEDATA, AVL_M_ADDR, 1'b0};
    if (!RESET) begin
      prev_stall = 1'b0;
      return;
    end
    chk("read_and_write", {62'd0, AVL_M_READ, AVL_M_WRITE} == 64'd3, 64'd0);
    if (prev_stall) chk("cmd_stable_in_stall", cur, prev_cmd);
    if (AVL_M_WRITE && !AVL_M_WAITREQUEST) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", AVL_M_ADDR, 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", AVL_M_ADDR, e[AW+DW-1:DW]);
        chk("write_data", AVL_M_WRITEDATA, e[DW-1:0]);
        chk("write_byte_en", AVL_M_BYTE_EN, 4'b1111);
      end
      mem[AVL_M_ADDR] = AVL_M_WRITEDATA;
    end
    if (AVL_M_READ && !AVL_M_WAITREQUEST) begin
      if (exp_rd_q.size() == 0) begin
        chk("unexpected_read_addr", AVL_M_ADDR, 64'hFFFF_FFFF);
      end else begin
        chk("read_addr", AVL_M_ADDR, exp_rd_q.pop_front());
      end
      rd_addr  = AVL_M_ADDR;
      rd_due   = cyc_ctr + 1 + rd_extra + (stall_mode ? $urandom_range(0, 2) : 0);
      rd_issue = rd_issue + 1;
    end
    prev_stall = (AVL_M_READ || AVL_M_WRITE) && AVL_M_WAITREQUEST;
    prev_cmd   = cur;
  endtask

  // Advances from just after one rising edge to just after the next.
  task automatic step();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic drive_start(input logic [AW-1:0] b, input logic [AW-1:0] c,
                             input logic [DW-1:0] p, input logic i, input logic v);
    START = 1'b1;
    BASE_ADDR = b;
    COUNT = c;
    PATTERN = p;
    INC = i;
    VERIFY = v;
  endtask

  // ---------------- command table ----------------
  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] count;
    logic [DW-1:0] pattern;
    logic          inc;
    logic          verify;
    logic          stall;
    int            corrupt;      // word index corrupted on read-back, -1 none
    logic          exp_err;
    logic [AW-1:0] exp_err_addr;
    int            exp_lat;      // START-to-DONE cycles, -1 not checked
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    int nrd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    stall_mode   = v.stall;
    corrupt_en   = (v.corrupt >= 0);
    corrupt_addr = v.base + AW'(v.corrupt);
    // Expected bus traffic straight from the command.
    for (int i = 0; i < int'(v.count); i++) begin
      a = v.base + AW'(i);
      d = v.pattern + (v.inc ? DW'(i) : DW'(0));
      exp_q.push_back({a, d});
    end
    if (v.verify) begin
      nrd = (v.corrupt >= 0) ? v.corrupt + 1 : int'(v.count);
      for (int i = 0; i < nrd; i++) exp_rd_q.push_back(v.base + AW'(i));
    end
    drive_start(v.base, v.count, v.pattern, v.inc, v.verify);
    step();
    cyc = 1;
    START = 1'b0;
    chk($sformatf("v%0d_busy_after_start", idx), BUSY, (v.count != 0));
    if (v.count != 0) begin
      // These must not disturb the running command.
      BASE_ADDR = AW'($urandom);
      COUNT = AW'($urandom);
      PATTERN = $urandom;
      INC = ~v.inc;
      VERIFY = ~v.verify;
    end
    while (!DONE && cyc < 5000) begin
      step();
      cyc++;
      START = 1'b0;
      if (cyc == 2 && BUSY && !DONE) START = 1'b1;
    end
    START = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), DONE, 1'b1);
    chk($sformatf("v%0d_busy_in_fin", idx), BUSY, 1'b0);
    if (v.exp_lat >= 0) chk($sformatf("v%0d_done_latency", idx), cyc, v.exp_lat);
    chk($sformatf("v%0d_err", idx), ERR, v.exp_err);
    chk($sformatf("v%0d_err_addr", idx), ERR_ADDR, v.exp_err_addr);
    chk($sformatf("v%0d_writes_left", idx), exp_q.size(), 0);
    chk($sformatf("v%0d_reads_left", idx), exp_rd_q.size(), 0);
    step();
    chk($sformatf("v%0d_done_one_cycle", idx), DONE, 1'b0);
    chk($sformatf("v%0d_idle_not_busy", idx), BUSY, 1'b0);
    chk($sformatf("v%0d_err_held", idx), ERR, v.exp_err);
    flush();
    // Let any stray read response drain before the next command.
    for (int i = 0; i < 4; i++) step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int start_issue;
    logic saw_done;
    logic saw_busy;

    vecs[0] = '{12'h000, 12'd600, 32'h2020_2020, 1'b0, 1'b0, 1'b0, -1, 1'b0, 12'h000, 601};
    vecs[1] = '{12'hFFE, 12'd4,   32'h0000_0010, 1'b1, 1'b0, 1'b0, -1, 1'b0, 12'h000, 5};
    vecs[2] = '{12'h100, 12'd8,   32'hA5A5_0000, 1'b1, 1'b1, 1'b0,  5, 1'b1, 12'h105, -1};
    vecs[3] = '{12'h7F0, 12'd16,  32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, -1, 1'b0, 12'h000, -1};
    vecs[4] = '{12'h123, 12'd0,   32'h1234_5678, 1'b1, 1'b1, 1'b0, -1, 1'b0, 12'h000, 1};
    vecs[5] = '{12'hFFD, 12'd6,   32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1, -1, 1'b0, 12'h000, -1};
    vecs[6] = '{12'h050, 12'd1,   32'h0000_0001, 1'b0, 1'b0, 1'b0, -1, 1'b0, 12'h000, 2};
    vecs[7] = '{12'hFFF, 12'd8,   32'h0BAD_F00D, 1'b0, 1'b1, 1'b1,  7, 1'b1, 12'h006, -1};
    vecs[8] = '{12'h300, 12'd10,  32'h5555_AAAA, 1'b1, 1'b0, 1'b1, -1, 1'b0, 12'h000, -1};

    // Reset state.
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_err_addr", ERR_ADDR, 0);
    chk("rst_read", AVL_M_READ, 1'b0);
    chk("rst_write", AVL_M_WRITE, 1'b0);
    chk("rst_addr", AVL_M_ADDR, 0);
    chk("rst_wdata", AVL_M_WRITEDATA, 0);
    chk("rst_byte_en", AVL_M_BYTE_EN, 4'b0000);
    RESET = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset in the middle of the write pass.
    stall_mode = 1'b0;
    corrupt_en = 1'b0;
    for (int i = 0; i < 20; i++) exp_q.push_back({AW'(12'h400 + i), DW'(32'h7700_0000 + i)});
    drive_start(12'h400, 12'd20, 32'h7700_0000, 1'b1, 1'b0);
    step();
    START = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_wr_writing", AVL_M_WRITE, 1'b1);
    RESET = 1'b0;
    step();
    chk("mid_wr_rst_busy", BUSY, 1'b0);
    chk("mid_wr_rst_write", AVL_M_WRITE, 1'b0);
    chk("mid_wr_rst_addr", AVL_M_ADDR, 0);
    chk("mid_wr_rst_byte_en", AVL_M_BYTE_EN, 4'b0000);
    chk("mid_wr_rst_done", DONE, 1'b0);
    RESET = 1'b1;
    flush();
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      saw_done |= DONE;
      saw_busy |= BUSY;
    end
    chk("mid_wr_no_done", saw_done, 1'b0);
    chk("mid_wr_stays_idle", saw_busy, 1'b0);

    // Reset while a read is outstanding; the response arrives after reset.
    rd_extra = 3;
    exp_q.push_back({12'h200, 32'hC0DE_0000});
    exp_q.push_back({12'h201, 32'hC0DE_0000});
    exp_rd_q.push_back(12'h200);
    exp_rd_q.push_back(12'h201);
    start_issue = int'(rd_issue);
    drive_start(12'h200, 12'd2, 32'hC0DE_0000, 1'b0, 1'b1);
    step();
    START = 1'b0;
    cyc = 1;
    while (int'(rd_issue) == start_issue && cyc < 50) begin
      step();
      cyc++;
    end
    chk("rd_wait_read_issued", int'(rd_issue) != start_issue, 1'b1);
    chk("rd_wait_busy", BUSY, 1'b1);
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    flush();
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      saw_done |= DONE;
      saw_busy |= BUSY;
    end
    chk("late_valid_no_done", saw_done, 1'b0);
    chk("late_valid_idle", saw_busy, 1'b0);
    chk("late_valid_no_err", ERR, 1'b0);
    chk("late_valid_served", rd_served, rd_issue);
    rd_extra = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_fill_master.md
VRAM_FILL_MASTER -- requirements
Module: vram_fill_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the Avalon-MM slave port.
REQ-002 SHALL have parameter DATA_W, default 32, Avalon data width.
REQ-003 SHALL have port CLK  input  1  system clock (50 MHz); all logic on posedge CLK.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have port START  input  1  one-cycle command strobe, sampled only in IDLE.
REQ-006 SHALL have port BASE_ADDR  input  ADDR_W  first word address; latched on accepted START.
REQ-007 SHALL have port COUNT  input  ADDR_W  number of words to write; latched on accepted START.
REQ-008 SHALL have port PATTERN  input  DATA_W  first data word; latched on accepted START.
REQ-009 SHALL have port INC  input  1  1 = data increments by 1 per word; 0 = constant; latched on accepted START.
REQ-010 SHALL have port VERIFY  input  1  1 = read-back pass after writes; latched on accepted START.
REQ-011 SHALL have port BUSY  output  1  high from the cycle after accepted START until DONE.
REQ-012 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-013 SHALL have port ERR  output  1  read-back mismatch flag; held until next accepted START.
REQ-014 SHALL have port ERR_ADDR  output  ADDR_W  address of first mismatch.
REQ-015 SHALL have ports AVL_M_ADDR (output, ADDR_W), AVL_M_READ (output, 1), AVL_M_WRITE (output, 1), AVL_M_BYTE_EN (output, 4), AVL_M_WRITEDATA (output, DATA_W): Avalon-MM master command signals.
REQ-016 SHALL have ports AVL_M_READDATA (input, DATA_W), AVL_M_WAITREQUEST (input, 1), AVL_M_READDATAVALID (input, 1): Avalon-MM master response signals.

Function
REQ-017 SHALL implement FSM states IDLE, WR, RD_REQ, RD_WAIT, FIN.
REQ-018 IDLE: START=1 SHALL latch the inputs, clear ERR and ERR_ADDR, load addr/data/remaining counters, and go to WR; if COUNT=0, SHALL go to FIN instead.
REQ-019 WR SHALL drive AVL_M_WRITE=1, AVL_M_BYTE_EN=4'b1111, AVL_M_ADDR=current addr, AVL_M_WRITEDATA=current data.
REQ-020 SHALL hold all command signals stable while AVL_M_WAITREQUEST=1; a transfer completes only on a cycle with WAITREQUEST=0.
REQ-021 On each completed write, SHALL increment addr modulo 2^ADDR_W, add INC to data modulo 2^DATA_W, and decrement remaining.
REQ-022 After the last write: VERIFY=1 -> reload addr/data/remaining from latched values and go to RD_REQ; VERIFY=0 -> go to FIN.
REQ-023 RD_REQ SHALL drive AVL_M_READ=1 with the current address and go to RD_WAIT when the request is accepted (WAITREQUEST=0); at most one read SHALL be outstanding.
REQ-024 RD_WAIT SHALL deassert READ and wait for READDATAVALID=1, then compare READDATA with the expected data.
REQ-025 On mismatch: set ERR=1, ERR_ADDR=addr, go to FIN (no further reads).
REQ-026 On match: advance as in REQ-021; go to RD_REQ if words remain, else FIN.
REQ-027 FIN SHALL pulse DONE=1 for exactly one cycle, then return to IDLE; BUSY SHALL be 0 in FIN.
REQ-028 START outside IDLE SHALL be ignored; input changes while BUSY SHALL have no effect.
REQ-029 AVL_M_READ and AVL_M_WRITE SHALL never both be 1; both SHALL be 0 in IDLE and FIN.
REQ-030 Minimum latency SHALL be: START to first WRITE 1 cycle; with WAITREQUEST=0 and VERIFY=0, DONE COUNT+1 cycles after START.
REQ-031 Address wrap: BASE_ADDR+COUNT > 2^ADDR_W SHALL wrap to 0 without error.

Reset
REQ-032 While RESET=0 at a clock edge, the FSM SHALL enter IDLE and BUSY, DONE, ERR, AVL_M_READ and AVL_M_WRITE SHALL be 0; ERR_ADDR, AVL_M_ADDR and AVL_M_WRITEDATA SHALL be 0; AVL_M_BYTE_EN SHALL be 4'b0000.
REQ-033 Reset mid-transfer SHALL abandon the operation; no DONE pulse; a late READDATAVALID after reset SHALL be ignored.

Verification
REQ-034 BASE=0x000, COUNT=600, PATTERN=0x20202020, INC=0, VERIFY=0, WAITREQUEST=0 -> 600 writes to 0x000..0x257; DONE at cycle 601; ERR=0.
REQ-035 BASE=0xFFE, COUNT=4, PATTERN=0x10, INC=1 -> writes 0xFFE=0x10, 0xFFF=0x11, 0x000=0x12, 0x001=0x13.
REQ-036 Random WAITREQUEST stalls on writes and reads -> command signals are stable during every stall; transfer count is exact.
REQ-037 VERIFY=1, COUNT=8, slave model corrupts word 5 -> ERR=1, ERR_ADDR=BASE+5, DONE pulses, no read of BASE+6.
REQ-038 COUNT=0 -> DONE one cycle after START with no bus activity; START while BUSY is ignored; RESET=0 during WR -> IDLE next edge, no DONE.
